imm_encoder: RTL and testbench

//   Elastic 2-stage pipelined RV32I instruction encoder, the inverse of the immediate

---
 rtl/imm_encoder.sv | 205 ++++++++++++++++++++
 tb/tb_imm_encoder.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: elastic two-stage RV32I instruction encoder.
//   This block does the reverse of the immediate decoder. It packs the format,
//   opcode, register fields, funct fields and a 32-bit immediate into one
//   instruction word. It flags immediates that cannot be represented and
//   opcodes that do not belong to the selected format.
//   When out_err=0, decoding out_insn gives back in_imm.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   flush                 synchronous drop of both stages (counters kept)
//   in_valid/in_ready     request handshake
//   in_fmt                0=R 1=I 2=S 3=B 4=U 5=J (6/7 invalid)
//   in_opcode..in_imm     instruction fields and sign-extended immediate
//   out_valid/out_ready   result handshake
//   out_insn, out_err     encoded word and its error flag
//   acc_cnt, err_cnt      saturating counts of accepted requests / errored outputs
//
// Parameters
//   CNT_W          counter width
//   ERR_ZERO_INSN  1: out_insn is forced to zero when out_err=1

module imm_encoder #(
  parameter int CNT_W         = 16,
  parameter bit ERR_ZERO_INSN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_insn,
  output logic             out_err,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Stage 1 holds the raw request.
  logic        s1_v;
  logic [2:0]  s1_fmt;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm;

  // Stage 2 holds the packed word.
  logic        s2_v;
  logic [31:0] s2_insn;
  logic        s2_err;

  logic s2_load;
  logic s1_adv;
  logic s1_load;
  logic acc_inc;
  logic err_inc;

  // in_ready depends only on stage occupancy, out_ready and flush.
  // No path runs from in_valid to any output.
  assign s2_load  = !s2_v || out_ready;
  assign s1_adv   = s1_v && s2_load;
  assign s1_load  = !s1_v || s1_adv;
  assign in_ready = s1_load && !flush;

  assign acc_inc = in_valid && in_ready;
  assign err_inc = s2_v && out_ready && s2_err;

  logic [31:0] enc_word;
  logic        imm_bad;
  logic        op_bad;
  logic        fmt_bad;
  logic        enc_err;
  logic [31:0] enc_out;

  always_comb begin
    enc_word = 32'h0;
    imm_bad  = 1'b0;
    op_bad   = 1'b0;
    fmt_bad  = 1'b0;
    unique case (s1_fmt)
      FMT_R: begin
        enc_word = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
        op_bad   = (s1_op != OP_OP);
      end
      FMT_I: begin
        enc_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
        imm_bad  = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
        op_bad   = !((s1_op == OP_IMM) || (s1_op == OP_LOAD) || (s1_op == OP_JALR));
      end
      FMT_S: begin
        enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
        imm_bad  = !((&s1_imm[31:11]) || !(|s1_imm[31:11]));
        op_bad   = (s1_op != OP_STORE);
      end
      FMT_B: begin
        enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                    s1_imm[4:1], s1_imm[11], s1_op};
        imm_bad  = !((&s1_imm[31:12]) || !(|s1_imm[31:12])) || s1_imm[0];
        op_bad   = (s1_op != OP_BRANCH);
      end
      FMT_U: begin
        enc_word = {s1_imm[31:12], s1_rd, s1_op};
        imm_bad  = |s1_imm[11:0];
        op_bad   = !((s1_op == OP_LUI) || (s1_op == OP_AUIPC));
      end
      FMT_J: begin
        enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
        imm_bad  = !((&s1_imm[31:20]) || !(|s1_imm[31:20])) || s1_imm[0];
        op_bad   = (s1_op != OP_JAL);
      end
      default: fmt_bad = 1'b1;
    endcase
    enc_err = imm_bad || op_bad || fmt_bad;
    enc_out = (ERR_ZERO_INSN && enc_err) ? 32'h0 : enc_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_fmt <= '0;
      s1_op  <= '0;
      s1_rd  <= '0;
      s1_rs1 <= '0;
      s1_rs2 <= '0;
      s1_f3  <= '0;
      s1_f7  <= '0;
      s1_imm <= '0;
    end else if (flush) begin
      s1_v <= 1'b0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_fmt <= in_fmt;
        s1_op  <= in_opcode;
        s1_rd  <= in_rd;
        s1_rs1 <= in_rs1;
        s1_rs2 <= in_rs2;
        s1_f3  <= in_funct3;
        s1_f7  <= in_funct7;
        s1_imm <= in_imm;
      end
    end
  end

  // The data registers only load with a valid word. This keeps out_insn and
  // out_err unchanged while the consumer stalls, and also when stage 2 drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_insn <= 32'h0;
      s2_err  <= 1'b0;
    end else if (flush) begin
      s2_v <= 1'b0;
    end else if (s2_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_insn <= enc_out;
        s2_err  <= enc_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (acc_inc && (acc_cnt != '1)) acc_cnt <= acc_cnt + 1'b1;
      if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign out_valid = s2_v;
  assign out_insn  = s2_insn;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        out_err;
  logic [15:0] acc_cnt, err_cnt;

  imm_encoder #(.CNT_W(16), .ERR_ZERO_INSN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_err(out_err),
    .acc_cnt(acc_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] insn;
    logic        err;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } sb_t;

  // Reference model. The error rule uses signed ranges and the bit packing
  // uses shifts, so it works from the ISA rules and not from the RTL logic.
  function automatic sb_t model(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm);
    sb_t r;
    longint s;
    logic [31:0] u;
    logic [31:0] base;
    bit op_ok, imm_ok;
    s = longint'($signed(imm));
    u = imm;
    base = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20);
    op_ok = 0;
    imm_ok = 1;
    r.insn = 32'h0;
    case (fmt)
      3'd0: begin op_ok = (op == 7'h33); r.insn = base | (32'(f7) << 25); end
      3'd1: begin
        op_ok = (op == 7'h13) || (op == 7'h03) || (op == 7'h67);
        imm_ok = (s >= -2048) && (s <= 2047);
        r.insn = (32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)) | ((u & 32'hfff) << 20);
      end
      3'd2: begin
        op_ok = (op == 7'h23);
        imm_ok = (s >= -2048) && (s <= 2047);
        r.insn = (base & ~(32'h1f << 7)) | ((u & 32'h1f) << 7) | (((u >> 5) & 32'h7f) << 25);
      end
      3'd3: begin
        op_ok = (op == 7'h63);
        imm_ok = (s >= -4096) && (s <= 4095) && ((u % 2) == 0);
        r.insn = (base & ~(32'h1f << 7)) | (((u >> 11) & 1) << 7) | (((u >> 1) & 32'hf) << 8)
               | (((u >> 5) & 32'h3f) << 25) | (((u >> 12) & 1) << 31);
      end
      3'd4: begin
        op_ok = (op == 7'h37) || (op == 7'h17);
        imm_ok = ((u % 4096) == 0);
        r.insn = (u & 32'hfffff000) | (32'(rd) << 7) | 32'(op);
      end
      3'd5: begin
        op_ok = (op == 7'h6f);
        imm_ok = (s >= -(64'sd1 << 20)) && (s <= (64'sd1 << 20) - 1) && ((u % 2) == 0);
        r.insn = 32'(op) | (32'(rd) << 7) | (((u >> 12) & 32'hff) << 12) | (((u >> 11) & 1) << 20)
               | (((u >> 1) & 32'h3ff) << 21) | (((u >> 20) & 1) << 31);
      end
      default: op_ok = 0;
    endcase
    r.err = !(op_ok && imm_ok);
    if (r.err) r.insn = 32'h0;
    r.fmt = fmt;
    r.imm = imm;
    return r;
  endfunction

  function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] w);
    logic [31:0] d;
    case (fmt)
      3'd1: d = {{20{w[31]}}, w[31:20]};
      3'd2: d = {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3: d = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4: d = {w[31:12], 12'h0};
      3'd5: d = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: d = 32'h0;
    endcase
    return d;
  endfunction

  sb_t sbq[$];
  bit prev_stall = 0;
  logic [31:0] prev_insn = 32'h0;
  logic prev_err = 1'b0;
  int cyc = 0;
  int n_acc = 0, n_out = 0, n_err_out = 0;
  int first_out_cyc = 0, last_out_cyc = 0;

  task automatic clear_stats();
    sbq.delete();
    prev_stall = 0;
    n_acc = 0; n_out = 0; n_err_out = 0;
  endtask

  // Inputs are set 1 time unit after the rising edge. Outputs are sampled at
  // the falling edge, and the model follows the handshakes that happen there.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_insn", out_insn, prev_insn);
      chk("stall_err", 32'(out_err), 32'(prev_err));
    end
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("unexpected_out", 32'(out_valid), 32'd0);
      else begin
        e = sbq.pop_front();
        chk("out_insn", out_insn, e.insn);
        chk("out_err", 32'(out_err), 32'(e.err));
        if (!e.err && e.fmt != 3'd0) chk("round_trip", decode_imm(e.fmt, out_insn), e.imm);
        if (e.err) n_err_out++;
      end
      if (n_out == 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      n_out++;
    end
    if (in_valid && in_ready) begin
      sbq.push_back(model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
      n_acc++;
    end
    prev_stall = out_valid && !out_ready && !flush;
    prev_insn = out_insn;
    prev_err = out_err;
    if (flush) sbq.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_stats();
  endtask

  task automatic gen_word();
    logic [6:0] ops [9];
    int k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
    k = int'($urandom_range(0, 9));
    in_fmt = (k > 7) ? 3'(6 + (k % 2)) : 3'(k % 6);
    case (in_fmt)
      3'd0: in_opcode = ops[0];
      3'd1: in_opcode = ops[1 + int'($urandom_range(0, 2))];
      3'd2: in_opcode = ops[4];
      3'd3: in_opcode = ops[5];
      3'd4: in_opcode = ops[6 + int'($urandom_range(0, 1))];
      default: in_opcode = ops[8];
    endcase
    if ($urandom_range(0, 9) == 0) in_opcode = 7'($urandom);
    in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
    in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0: in_imm = $urandom;
      1: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: begin
        logic [31:0] b [10];
        b = '{32'd2047, 32'hfffff800, 32'd2048, 32'hfffff7ff, 32'd4094,
              32'hfffff000, 32'd4095, 32'h000ffffe, 32'hfff00000, 32'h00100000};
        in_imm = b[$urandom_range(0, 9)];
      end
      default: in_imm = ($urandom & 32'hfffff000) | (($urandom_range(0, 1) == 1) ? 32'h0 : 32'($urandom_range(0, 4095)));
    endcase
  endtask

  typedef struct {
    logic [2:0] fmt; logic [6:0] op; logic [4:0] rd, rs1, rs2;
    logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
    logic [31:0] insn; logic err;
  } vec_t;

  vec_t tbl [14];
  int n_tbl_err;
  int acc_before;
  bit last_rdy;

  initial begin
    tbl[0]  = '{3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'h00, 32'hffffffff, 32'hfff30293, 1'b0};
    tbl[1]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hfffffffc, 32'hfe208ee3, 1'b0};
    tbl[2]  = '{3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123450b7, 1'b0};
    tbl[3]  = '{3'd5, 7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 32'h008000ef, 1'b0};
    tbl[4]  = '{3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hdeadbeef, 32'h403100b3, 1'b0};
    tbl[5]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h00000008, 32'h0020a423, 1'b0};
    tbl[6]  = '{3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hfffff800, 32'h80000013, 1'b0};
    tbl[7]  = '{3'd5, 7'h6f, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hfff00000, 32'h8000006f, 1'b0};
    tbl[8]  = '{3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h00000000, 1'b1};
    tbl[9]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000003, 32'h00000000, 1'b1};
    tbl[10] = '{3'd1, 7'h33, 5'd5, 5'd6, 5'd0, 3'd0, 7'h00, 32'h00000004, 32'h00000000, 1'b1};
    tbl[11] = '{3'd6, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'h00, 32'h00000004, 32'h00000000, 1'b1};
    tbl[12] = '{3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'h00000000, 1'b1};
    tbl[13] = '{3'd5, 7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000007, 32'h00000000, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = 3'd0; in_opcode = 7'h0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 32'h0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_insn", out_insn, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, one at a time, with the two-cycle latency checked.
    n_tbl_err = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_fmt = tbl[i].fmt; in_opcode = tbl[i].op; in_rd = tbl[i].rd; in_rs1 = tbl[i].rs1;
      in_rs2 = tbl[i].rs2; in_funct3 = tbl[i].f3; in_funct7 = tbl[i].f7; in_imm = tbl[i].imm;
      in_valid = 1'b1;
      if (tbl[i].err) n_tbl_err++;
      @(negedge clk);
      chk($sformatf("vec%0d_accept", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_lat1", i), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_insn", i), out_insn, tbl[i].insn);
      chk($sformatf("vec%0d_err", i), 32'(out_err), 32'(tbl[i].err));
      @(posedge clk); #1;
    end
    chk("tbl_acc_cnt", 32'(acc_cnt), 32'd14);
    chk("tbl_err_cnt", 32'(err_cnt), 32'(n_tbl_err));

    // Streaming: 8 back-to-back words.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      gen_word();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && sbq.size() > 0; k++) tick();
    chk("stream_accepted", 32'(n_acc), 32'd8);
    chk("stream_outputs", 32'(n_out), 32'd8);
    chk("stream_consecutive", 32'(last_out_cyc - first_out_cyc), 32'd7);
    chk("stream_acc_cnt", 32'(acc_cnt), 32'd8);

    // Backpressure: out_ready low for 4 cycles while 3 words are offered.
    do_reset();
    out_ready = 1'b0;
    last_rdy = 1'b1;
    gen_word();
    for (int c = 0; c < 4; c++) begin
      in_valid = (n_acc < 3);
      last_rdy = in_ready;
      acc_before = n_acc;
      tick();
      if (n_acc != acc_before) gen_word();
    end
    chk("bp_accepted", 32'(n_acc), 32'd2);
    chk("bp_in_ready_low", 32'(last_rdy), 32'd0);
    chk("bp_acc_cnt", 32'(acc_cnt), 32'd2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && sbq.size() > 0; k++) tick();
    chk("bp_drain", 32'(sbq.size()), 32'd0);
    chk("bp_outputs", 32'(n_out), 32'd2);

    // Flush with two words in flight.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin gen_word(); in_valid = 1'b1; tick(); end
    chk("flush_pre_valid", 32'(out_valid), 32'd1);
    gen_word();
    in_valid = 1'b1;
    flush = 1'b1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_acc_cnt", 32'(acc_cnt), 32'd2);
    chk("flush_err_cnt", 32'(err_cnt), 32'd0);
    out_ready = 1'b1;
    tick(); tick();
    chk("flush_empty", 32'(out_valid), 32'd0);
    chk("flush_outputs", 32'(n_out), 32'd0);

    // Asynchronous reset in the middle of a stream.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin gen_word(); in_valid = 1'b1; tick(); end
    chk("rstmid_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);
    chk("rstmid_out_insn", out_insn, 32'h0);
    chk("rstmid_acc_cnt", 32'(acc_cnt), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    clear_stats();

    // Random traffic against the reference model with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      gen_word();
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sbq.size() > 0; k++) tick();
    chk("rand_drain", 32'(sbq.size()), 32'd0);
    chk("rand_acc_cnt", 32'(acc_cnt), 32'(n_acc));
    chk("rand_err_cnt", 32'(err_cnt), 32'(n_err_out));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
